wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive lost cycles before hold_req is raised; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 regwrite_reg  input  1  MEM/WB write-enable of the writeback stage.
REQ-005 memtoreg_reg  input  1  MEM/WB select: 1 = memory data, 0 = ALU result.
REQ-006 readdata_reg  input  64  MEM/WB memory read data.
REQ-007 aluresult_reg  input  64  MEM/WB ALU result.
REQ-008 rd_reg  input  5  MEM/WB destination register.
REQ-009 lu_valid  input  1  long-latency unit (mul/div) result request.
REQ-010 lu_data  input  64  long-latency unit result.
REQ-011 lu_rd  input  5  long-latency unit destination register.
REQ-012 lu_ready  output  1  combinational grant to the long-latency unit.
REQ-013 rf_we  output  1  registered register-file write enable.
REQ-014 rf_waddr  output  5  registered register-file write address.
REQ-015 rf_wdata  output  64  registered register-file write data.
REQ-016 hold_req  output  1  registered request to the hazard unit to inject a writeback bubble.
REQ-017 conflict_cnt  output  16  saturating count of cycles with lu_valid=1 and lu_ready=0.

Function
REQ-018 pipe_wr = regwrite_reg AND (rd_reg != 0); pipe_wr has absolute priority and is never dropped or delayed.
REQ-019 lu_ready = NOT pipe_wr, independent of lu_valid and of state.
REQ-020 Transfer occurs in a cycle with lu_valid=1 and lu_ready=1; the unit holds lu_valid, lu_data, lu_rd stable until transfer.
REQ-021 Next-cycle write: pipe_wr -> rf_we=1, rf_waddr=rd_reg, rf_wdata=(memtoreg_reg ? readdata_reg : aluresult_reg).
REQ-022 Else on transfer with lu_rd != 0 -> rf_we=1, rf_waddr=lu_rd, rf_wdata=lu_data.
REQ-023 Else rf_we=0; rf_waddr, rf_wdata hold previous values; transfer with lu_rd=0 is consumed without a write.
REQ-024 regwrite_reg=1 with rd_reg=0 writes nothing and leaves the port free to the long-latency unit that cycle.
REQ-025 Latency: input cycle N -> rf_* valid in cycle N+1; exactly one write per cycle maximum.
REQ-026 FSM states IDLE, WAIT, HOLD; 4-bit lose counter cnt.
REQ-027 IDLE: lu_valid AND NOT lu_ready -> WAIT, cnt=1; otherwise stay IDLE, cnt=0.
REQ-028 WAIT: transfer -> IDLE, cnt=0; lu_valid=0 -> IDLE, cnt=0; loss with cnt+1 = STARVE_LIMIT -> HOLD; else loss -> cnt=cnt+1.
REQ-029 STARVE_LIMIT=1: the first loss in IDLE goes directly to HOLD.
REQ-030 HOLD: hold_req=1 (registered, equals state==HOLD); transfer -> IDLE; lu_valid=0 -> IDLE; otherwise remain in HOLD regardless of duration.
REQ-031 hold_req deasserts the cycle after the transfer.
REQ-032 conflict_cnt increments by 1 per cycle with lu_valid=1 AND lu_ready=0, saturates at 0xFFFF, never wraps.

Reset
REQ-033 During reset: state=IDLE, cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, hold_req=0, conflict_cnt=0.
REQ-034 lu_ready remains combinational during reset; a transfer coincident with reset is discarded; the unit re-presents after reset.
REQ-035 Reset mid-WAIT/HOLD returns to IDLE next cycle with no write issued.

Verification
REQ-036 Pipe-only: regwrite_reg=1, memtoreg_reg=1, rd_reg=5, readdata_reg=0xAA -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xAA; memtoreg_reg=0, aluresult_reg=0x55 -> rf_wdata=0x55.
REQ-037 Free port: regwrite_reg=0, lu_valid=1, lu_rd=7, lu_data=0x1234 -> lu_ready=1; next cycle rf_we=1, rf_waddr=7, rf_wdata=0x1234; hold_req stays 0.
REQ-038 x0 cases: regwrite_reg=1, rd_reg=0, lu_rd=3 -> lu_ready=1 and reg 3 written; separately, transfer with lu_rd=0 -> rf_we=0 next cycle.
REQ-039 Starvation at STARVE_LIMIT=4: pipe_wr=1 continuously with lu_valid=1 -> hold_req=1 from the 5th cycle; conflict_cnt=4 at that point; first bubble -> transfer, hold_req=0 the following cycle.
REQ-040 Saturation: 70000 consecutive conflict cycles -> conflict_cnt=0xFFFF, with no wrap.
REQ-041 Reset mid-HOLD: assert reset in HOLD -> next cycle hold_req=0, rf_we=0, conflict_cnt=0, state IDLE.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: MEM/WB pipe write, long-latency unit request/grant and register-file write outputs.
// Both the arbiter and its driver use this bundle, through opposite modports.
interface wb_port_arbiter_if;
    logic        regwrite_reg;
    logic        memtoreg_reg;
    logic [63:0] readdata_reg;
    logic [63:0] aluresult_reg;
    logic [4:0]  rd_reg;
    logic        lu_valid;
    logic [63:0] lu_data;
    logic [4:0]  lu_rd;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        hold_req;
    logic [15:0] conflict_cnt;

    modport master (
        output regwrite_reg, memtoreg_reg, readdata_reg, aluresult_reg, rd_reg,
        output lu_valid, lu_data, lu_rd,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, hold_req, conflict_cnt
    );

    modport slave (
        input  regwrite_reg, memtoreg_reg, readdata_reg, aluresult_reg, rd_reg,
        input  lu_valid, lu_data, lu_rd,
        output lu_ready, rf_we, rf_waddr, rf_wdata, hold_req, conflict_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB pipe (absolute priority) and a long-latency unit.
// One-cycle write latency; the unit is stalled via lu_ready and a starvation FSM raises hold_req.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       pipe_wr;
    logic       xfer;
    logic       loss;

    assign pipe_wr = bus.regwrite_reg && (bus.rd_reg != 5'd0);
    assign xfer    = bus.lu_valid && !pipe_wr;
    assign loss    = bus.lu_valid && pipe_wr;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: cnt counts consecutive lost cycles while the unit keeps requesting
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (loss) begin
                    state_nxt = (LIMIT == 4'd1) ? HOLD : WAIT;
                    cnt_nxt   = 4'd1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            WAIT: begin
                if (!loss) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    state_nxt = (cnt + 4'd1 == LIMIT) ? HOLD : WAIT;
                    cnt_nxt   = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (!loss) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs: grant is purely combinational, hold_req is decoded from the registered state
    always_comb begin
        bus.lu_ready = !pipe_wr;
        bus.hold_req = (state == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_we        <= 1'b0;
            bus.rf_waddr     <= 5'd0;
            bus.rf_wdata     <= 64'd0;
            bus.conflict_cnt <= 16'd0;
        end else begin
            if (pipe_wr) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= bus.rd_reg;
                bus.rf_wdata <= bus.memtoreg_reg ? bus.readdata_reg : bus.aluresult_reg;
            end else if (xfer && (bus.lu_rd != 5'd0)) begin
                bus.rf_we    <= 1'b1;
                bus.rf_waddr <= bus.lu_rd;
                bus.rf_wdata <= bus.lu_data;
            end else begin
                bus.rf_we    <= 1'b0;
            end

            if (loss && (bus.conflict_cnt != 16'hFFFF))
                bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter at STARVE_LIMIT=4 with hand-computed expectations.
module tb_wb_port_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.regwrite_reg  = 1'b0;
        bus.memtoreg_reg  = 1'b0;
        bus.readdata_reg  = 64'd0;
        bus.aluresult_reg = 64'd0;
        bus.rd_reg        = 5'd0;
        bus.lu_valid      = 1'b0;
        bus.lu_data       = 64'd0;
        bus.lu_rd         = 5'd0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        idle_inputs();

        // Reset with a transfer offered: grant stays combinational, transfer is discarded
        reset        = 1'b1;
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd3;
        bus.lu_data  = 64'h77;
        #1;
        chk("rst_lu_ready", 64'(bus.lu_ready), 64'd1);
        step();
        step();
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_rf_wdata", bus.rf_wdata, 64'd0);
        chk("rst_hold", 64'(bus.hold_req), 64'd0);
        chk("rst_conflict", 64'(bus.conflict_cnt), 64'd0);
        idle_inputs();
        reset = 1'b0;
        step();
        chk("post_rst_we", 64'(bus.rf_we), 64'd0);

        // Pipe-only writes, both mux selections
        bus.regwrite_reg  = 1'b1;
        bus.memtoreg_reg  = 1'b1;
        bus.rd_reg        = 5'd5;
        bus.readdata_reg  = 64'hAA;
        bus.aluresult_reg = 64'h99;
        step();
        chk("pipe_mem_we", 64'(bus.rf_we), 64'd1);
        chk("pipe_mem_addr", 64'(bus.rf_waddr), 64'd5);
        chk("pipe_mem_data", bus.rf_wdata, 64'hAA);
        bus.memtoreg_reg  = 1'b0;
        bus.aluresult_reg = 64'h55;
        step();
        chk("pipe_alu_data", bus.rf_wdata, 64'h55);

        // No request: no write, address/data hold
        idle_inputs();
        step();
        chk("idle_we", 64'(bus.rf_we), 64'd0);
        chk("idle_addr_hold", 64'(bus.rf_waddr), 64'd5);
        chk("idle_data_hold", bus.rf_wdata, 64'h55);

        // Free port: unit transfer
        bus.lu_valid = 1'b1;
        bus.lu_rd    = 5'd7;
        bus.lu_data  = 64'h1234;
        #1;
        chk("free_lu_ready", 64'(bus.lu_ready), 64'd1);
        step();
        chk("free_we", 64'(bus.rf_we), 64'd1);
        chk("free_addr", 64'(bus.rf_waddr), 64'd7);
        chk("free_data", bus.rf_wdata, 64'h1234);
        chk("free_hold", 64'(bus.hold_req), 64'd0);
        chk("free_conflict", 64'(bus.conflict_cnt), 64'd0);

        // Pipe write to x0 leaves the port to the unit
        bus.regwrite_reg  = 1'b1;
        bus.rd_reg        = 5'd0;
        bus.aluresult_reg = 64'hDEAD;
        bus.lu_rd         = 5'd3;
        bus.lu_data       = 64'h33;
        #1;
        chk("x0_lu_ready", 64'(bus.lu_ready), 64'd1);
        step();
        chk("x0_we", 64'(bus.rf_we), 64'd1);
        chk("x0_addr", 64'(bus.rf_waddr), 64'd3);
        chk("x0_data", bus.rf_wdata, 64'h33);

        // Unit transfer to x0 is consumed without a write
        bus.regwrite_reg = 1'b0;
        bus.lu_rd        = 5'd0;
        bus.lu_data      = 64'hBEEF;
        step();
        chk("lu_x0_we", 64'(bus.rf_we), 64'd0);
        chk("lu_x0_data_hold", bus.rf_wdata, 64'h33);

        // Starvation: continuous pipe writes against a pending unit request
        bus.regwrite_reg  = 1'b1;
        bus.memtoreg_reg  = 1'b0;
        bus.rd_reg        = 5'd9;
        bus.lu_rd         = 5'd4;
        bus.lu_data       = 64'h44;
        for (int i = 1; i <= 4; i++) begin
            bus.aluresult_reg = 64'h100 + 64'(i);
            #1;
            chk("starve_lu_ready", 64'(bus.lu_ready), 64'd0);
            step();
            chk("starve_pipe_addr", 64'(bus.rf_waddr), 64'd9);
            chk("starve_pipe_data", bus.rf_wdata, 64'h100 + 64'(i));
            chk("starve_hold", 64'(bus.hold_req), (i == 4) ? 64'd1 : 64'd0);
            chk("starve_conflict", 64'(bus.conflict_cnt), 64'(i));
        end
        step();
        chk("hold_stays", 64'(bus.hold_req), 64'd1);
        chk("hold_conflict5", 64'(bus.conflict_cnt), 64'd5);
        // First bubble: unit transfers, hold drops next cycle
        bus.regwrite_reg = 1'b0;
        step();
        chk("bubble_we", 64'(bus.rf_we), 64'd1);
        chk("bubble_addr", 64'(bus.rf_waddr), 64'd4);
        chk("bubble_data", bus.rf_wdata, 64'h44);
        chk("bubble_hold", 64'(bus.hold_req), 64'd0);
        chk("bubble_conflict", 64'(bus.conflict_cnt), 64'd5);
        bus.lu_valid = 1'b0;
        step();

        // Reach HOLD again, then reset in HOLD
        bus.regwrite_reg = 1'b1;
        bus.lu_valid     = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("hold2_hold", 64'(bus.hold_req), 64'd1);
        chk("hold2_conflict", 64'(bus.conflict_cnt), 64'd9);
        reset = 1'b1;
        step();
        chk("rst_hold_hold", 64'(bus.hold_req), 64'd0);
        chk("rst_hold_we", 64'(bus.rf_we), 64'd0);
        chk("rst_hold_conflict", 64'(bus.conflict_cnt), 64'd0);
        reset = 1'b0;
        // Lose counter restarted from zero: HOLD only after four more losses
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("restarve_hold", 64'(bus.hold_req), (i == 4) ? 64'd1 : 64'd0);
        end
        bus.lu_valid = 1'b0;
        step();
        chk("withdraw_hold", 64'(bus.hold_req), 64'd0);
        chk("withdraw_conflict", 64'(bus.conflict_cnt), 64'd4);

        // Saturation of conflict_cnt
        reset = 1'b1;
        step();
        reset        = 1'b0;
        bus.lu_valid = 1'b1;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(bus.conflict_cnt), 64'hFFFE);
        for (int i = 0; i < 70000 - 65534; i++) @(posedge clk);
        #1;
        chk("sat_ffff", 64'(bus.conflict_cnt), 64'hFFFF);
        chk("sat_hold", 64'(bus.hold_req), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
